// File: rtl/regfile_access_ctrl.sv
// regfile_access_ctrl: operand-read / writeback front end for a
// synchronous-read register file, with write forwarding and hold.
module regfile_access_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_rs1,
  input  logic [ADDR_W-1:0] req_rs2,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data1,
  output logic [DATA_W-1:0] rsp_data2,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [ADDR_W-1:0] rf_read_addr1,
  output logic [ADDR_W-1:0] rf_read_addr2,
  output logic [ADDR_W-1:0] rf_write_addr,
  output logic              rf_write_en,
  output logic [DATA_W-1:0] rf_write_data,
  input  logic [DATA_W-1:0] rf_read_data1,
  input  logic [DATA_W-1:0] rf_read_data2
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RESP = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic              r_fwd1;
  logic              r_fwd2;
  logic [DATA_W-1:0] r_fwd_data;
  logic [DATA_W-1:0] r_hold1;
  logic [DATA_W-1:0] r_hold2;

  logic              w_fire;
  logic              w_hit1;
  logic              w_hit2;
  logic [DATA_W-1:0] w_live1;
  logic [DATA_W-1:0] w_live2;

  assign rf_read_addr1 = req_rs1;
  assign rf_read_addr2 = req_rs2;

  assign wb_ready      = !rst;
  assign rf_write_en   = wb_valid & wb_ready;
  assign rf_write_addr = wb_addr;
  assign rf_write_data = wb_data;

  assign w_fire = req_valid & req_ready;

  // The file returns the pre-write value on a same-edge write.
  assign w_hit1 = rf_write_en & (wb_addr == req_rs1);
  assign w_hit2 = rf_write_en & (wb_addr == req_rs2);

  assign w_live1 = r_fwd1 ? r_fwd_data : rf_read_data1;
  assign w_live2 = r_fwd2 ? r_fwd_data : rf_read_data2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        w_next = w_fire ? RESP : IDLE;
      end
      RESP: begin
        if (rsp_ready) begin
          w_next = w_fire ? RESP : IDLE;
        end else begin
          w_next = HOLD;
        end
      end
      HOLD: begin
        if (rsp_ready) begin
          w_next = w_fire ? RESP : IDLE;
        end else begin
          w_next = HOLD;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_data1 = '0;
    rsp_data2 = '0;
    unique case (r_state)
      IDLE: begin
        req_ready = 1'b1;
      end
      RESP: begin
        req_ready = rsp_ready;
        rsp_valid = 1'b1;
        rsp_data1 = w_live1;
        rsp_data2 = w_live2;
      end
      HOLD: begin
        req_ready = rsp_ready;
        rsp_valid = 1'b1;
        rsp_data1 = r_hold1;
        rsp_data2 = r_hold2;
      end
      default: begin
        req_ready = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fwd1     <= 1'b0;
      r_fwd2     <= 1'b0;
      r_fwd_data <= '0;
    end else if (w_fire) begin
      r_fwd1     <= w_hit1;
      r_fwd2     <= w_hit2;
      r_fwd_data <= wb_data;
    end else if (w_next == IDLE) begin
      r_fwd1     <= 1'b0;
      r_fwd2     <= 1'b0;
    end
  end

  // Freeze the live operands the first cycle the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold1 <= '0;
      r_hold2 <= '0;
    end else if ((r_state == RESP) && !rsp_ready) begin
      r_hold1 <= w_live1;
      r_hold2 <= w_live2;
    end
  end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// tb_regfile_access_ctrl: directed and random checks of the register
// file access controller against a snapshot-queue reference model.
module tb_regfile_access_ctrl;
  localparam int DW = 16;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready;
  logic [AW-1:0] req_rs1, req_rs2;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_data1, rsp_data2;
  logic          wb_valid, wb_ready;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic [AW-1:0] rf_read_addr1, rf_read_addr2, rf_write_addr;
  logic          rf_write_en;
  logic [DW-1:0] rf_write_data;
  logic [DW-1:0] rf_read_data1, rf_read_data2;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  regfile_access_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rs1(req_rs1), .req_rs2(req_rs2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data1(rsp_data1), .rsp_data2(rsp_data2),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_addr(wb_addr), .wb_data(wb_data),
    .rf_read_addr1(rf_read_addr1), .rf_read_addr2(rf_read_addr2),
    .rf_write_addr(rf_write_addr), .rf_write_en(rf_write_en),
    .rf_write_data(rf_write_data),
    .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2)
  );

  // Register file: synchronous read, read-before-write.
  logic [DW-1:0] rf_mem [8] = '{default: '0};
  always @(posedge clk) begin
    rf_read_data1 <= rf_mem[rf_read_addr1];
    rf_read_data2 <= rf_mem[rf_read_addr2];
    if (rf_write_en) rf_mem[rf_write_addr] <= rf_write_data;
  end

  // Reference: architectural register state plus one pending response.
  logic [DW-1:0] ref_mem [8] = '{default: '0};
  bit            m_pend = 1'b0;
  bit            m_fire;
  logic [DW-1:0] m_d1, m_d2;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pend = 1'b0;
    end else begin
      m_fire = req_valid && (!m_pend || rsp_ready);
      if (m_fire) begin
        m_d1 = (wb_valid && wb_addr == req_rs1) ? wb_data : ref_mem[req_rs1];
        m_d2 = (wb_valid && wb_addr == req_rs2) ? wb_data : ref_mem[req_rs2];
      end
      m_pend = m_fire || (m_pend && !rsp_ready);
      if (wb_valid) ref_mem[wb_addr] = wb_data;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  bit go = 1'b0;
  always @(negedge clk) begin
    if (go) begin
      if (rst) begin
        chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("rst_rsp_data1", 32'(rsp_data1), 32'(0));
        chk("rst_rsp_data2", 32'(rsp_data2), 32'(0));
        chk("rst_wb_ready", 32'(wb_ready), 32'(0));
        chk("rst_write_en", 32'(rf_write_en), 32'(0));
      end else begin
        chk("rsp_valid", 32'(rsp_valid), 32'(m_pend));
        chk("req_ready", 32'(req_ready), 32'(!m_pend || rsp_ready));
        if (m_pend) begin
          chk("rsp_data1", 32'(rsp_data1), 32'(m_d1));
          chk("rsp_data2", 32'(rsp_data2), 32'(m_d2));
        end
        chk("wb_ready", 32'(wb_ready), 32'(1));
        chk("write_en", 32'(rf_write_en), 32'(wb_valid));
        chk("write_addr", 32'(rf_write_addr), 32'(wb_addr));
        chk("write_data", 32'(rf_write_data), 32'(wb_data));
        chk("read_addr1", 32'(rf_read_addr1), 32'(req_rs1));
        chk("read_addr2", 32'(rf_read_addr2), 32'(req_rs2));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wb_valid = 1'b1;
    wb_addr  = a;
    wb_data  = d;
    step();
    wb_valid = 1'b0;
  endtask

  logic [DW-1:0] exp4 [4];

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_rs1 = '0; req_rs2 = '0;
    rsp_ready = 1'b1;
    wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
    go = 1'b1;
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("lit_reset_req_ready", 32'(req_ready), 32'(1));
    chk("lit_reset_rsp_valid", 32'(rsp_valid), 32'(0));
    step();

    // write then read
    wr(3'd3, 16'h1234);
    req_valid = 1'b1; req_rs1 = 3'd3; req_rs2 = 3'd0;
    step();
    req_valid = 1'b0;
    @(negedge clk);
    chk("lit_t1_valid", 32'(rsp_valid), 32'(1));
    chk("lit_t1_d1", 32'(rsp_data1), 32'h1234);
    chk("lit_t1_d2", 32'(rsp_data2), 32'h0000);
    step();

    // same-edge forward to both operands
    wr(3'd5, 16'h0001);
    wb_valid = 1'b1; wb_addr = 3'd5; wb_data = 16'hBEEF;
    req_valid = 1'b1; req_rs1 = 3'd5; req_rs2 = 3'd5;
    step();
    wb_valid = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    chk("lit_t2_d1", 32'(rsp_data1), 32'hBEEF);
    chk("lit_t2_d2", 32'(rsp_data2), 32'hBEEF);
    step();

    // backpressure with a later write to the held register
    wr(3'd2, 16'h00AA);
    req_valid = 1'b1; req_rs1 = 3'd2; req_rs2 = 3'd2;
    rsp_ready = 1'b0;
    step();
    req_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wb_valid = (k == 1);
      wb_addr = 3'd2; wb_data = 16'h5555;
      @(negedge clk);
      chk("lit_t3_valid", 32'(rsp_valid), 32'(1));
      chk("lit_t3_d1", 32'(rsp_data1), 32'h00AA);
      chk("lit_t3_ready", 32'(req_ready), 32'(0));
      step();
    end
    wb_valid = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_rs1 = 3'd2; req_rs2 = 3'd0;
    @(negedge clk);
    chk("lit_t3_release_d1", 32'(rsp_data1), 32'h00AA);
    chk("lit_t3_release_ready", 32'(req_ready), 32'(1));
    step();
    req_valid = 1'b0;
    @(negedge clk);
    chk("lit_t3_new_d1", 32'(rsp_data1), 32'h5555);
    step();

    // back-to-back stream
    exp4[0] = 16'h0000; exp4[1] = 16'h0000;
    exp4[2] = 16'h5555; exp4[3] = 16'h1234;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_rs1 = AW'(i); req_rs2 = AW'(3 - i);
      step();
      @(negedge clk);
      chk("lit_t4_valid", 32'(rsp_valid), 32'(1));
      chk("lit_t4_d1", 32'(rsp_data1), 32'(exp4[i]));
      chk("lit_t4_d2", 32'(rsp_data2), 32'(exp4[3-i]));
    end
    req_valid = 1'b0;
    step();

    // asynchronous reset while holding
    req_valid = 1'b1; req_rs1 = 3'd3; req_rs2 = 3'd3;
    rsp_ready = 1'b0;
    step();
    req_valid = 1'b0;
    step();
    #2;
    wb_valid = 1'b1; wb_addr = 3'd4; wb_data = 16'hDEAD;
    rst = 1'b1;
    #1;
    chk("lit_t5_valid", 32'(rsp_valid), 32'(0));
    chk("lit_t5_d1", 32'(rsp_data1), 32'(0));
    chk("lit_t5_we", 32'(rf_write_en), 32'(0));
    step();
    wb_valid = 1'b0;
    step();
    rst = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("lit_t5_ready", 32'(req_ready), 32'(1));
    step();

    // forward only to rs2
    wr(3'd1, 16'h1111);
    wb_valid = 1'b1; wb_addr = 3'd7; wb_data = 16'h0F0F;
    req_valid = 1'b1; req_rs1 = 3'd1; req_rs2 = 3'd7;
    step();
    wb_valid = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    chk("lit_t6_d1", 32'(rsp_data1), 32'h1111);
    chk("lit_t6_d2", 32'(rsp_data2), 32'h0F0F);
    step();

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
      end
      req_valid = 1'($urandom_range(0, 3) != 0);
      req_rs1   = AW'($urandom_range(0, 7));
      req_rs2   = AW'($urandom_range(0, 7));
      rsp_ready = 1'($urandom_range(0, 2) != 0);
      wb_valid  = 1'($urandom_range(0, 1));
      wb_addr   = AW'($urandom_range(0, 7));
      wb_data   = DW'($urandom);
      step();
    end
    req_valid = 1'b0; wb_valid = 1'b0; rsp_ready = 1'b1;
    step();
    step();
    go = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
